// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared sizes and the source-select type for the register file write-back arbiter.
package regfile_wb_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the last-granted pointer moves only on a completed transfer.
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    src_e last;

    // On contention the requester that did not win last time is served.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == SRC_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= SRC_B;
        end else if (advance) begin
            last <= gnt[0] ? SRC_A : SRC_B;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU (A) and load (B) writebacks and
// keeps a busy scoreboard of outstanding destinations for decode hazard detection.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_rd,
    input  logic [XLEN-1:0] a_wdata,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_rd,
    input  logic [XLEN-1:0] b_wdata,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            hazard,
    output logic [NREG-1:0] busy,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wdata
);

    // Handshake: a transfer happens on a posedge where valid && ready. ready is a
    // function of valid (never the reverse); a source holds rd/wdata while stalled.
    logic [1:0]      gnt;
    logic            xfer;
    logic            wr_fire;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_wdata;
    logic [NREG-1:0] busy_next;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({b_valid, a_valid}),
        .advance (xfer),
        .gnt     (gnt)
    );

    assign a_ready   = gnt[0];
    assign b_ready   = gnt[1];
    assign xfer      = (a_valid & a_ready) | (b_valid & b_ready);
    assign sel_rd    = gnt[1] ? b_rd : a_rd;
    assign sel_wdata = gnt[1] ? b_wdata : a_wdata;
    // A transfer to x0 completes the handshake but never reaches the register file.
    assign wr_fire   = xfer && (sel_rd != '0);

    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else if (rf_we) begin
            busy_next[rf_rd] = 1'b0;
        end
        // Issue is applied last so a new owner beats a same-edge retirement or flush.
        if (iss_valid && (iss_rd != '0)) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            busy     <= '0;
        end else begin
            rf_we <= wr_fire;
            if (wr_fire) begin
                rf_rd    <= sel_rd;
                rf_wdata <= sel_wdata;
            end
            busy <= busy_next;
        end
    end

    assign hazard = ((rs1 != '0) && busy[rs1]) || ((rs2 != '0) && busy[rs2]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter with hand-written multi-cycle sequences.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset_n;
    logic        a_valid, a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_wdata;
    logic        b_valid, b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        flush;
    logic [4:0]  rs1, rs2;
    logic        hazard;
    logic [31:0] busy;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    int tests_run = 0;
    int tests_failed = 0;
    logic [4:0] exp_q[$];
    logic [31:0] tb_rf [32];

    regfile_wb_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_rd      (a_rd),
        .a_wdata   (a_wdata),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_rd      (b_rd),
        .b_wdata   (b_wdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .rs1       (rs1),
        .rs2       (rs2),
        .hazard    (hazard),
        .busy      (busy),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model fed by the write port
    always_ff @(posedge clk) begin
        if (rf_we && (rf_rd != 5'd0)) tb_rf[rf_rd] <= rf_wdata;
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] awd;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bwd;
        logic        iv;
        logic [4:0]  ird;
        logic        fl;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_ar;
        logic        e_br;
        logic        e_hz;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_rd = 5'd0; a_wdata = 32'd0;
        b_valid = 1'b0; b_rd = 5'd0; b_wdata = 32'd0;
        iss_valid = 1'b0; iss_rd = 5'd0; flush = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        a_valid = v.av; a_rd = v.ard; a_wdata = v.awd;
        b_valid = v.bv; b_rd = v.brd; b_wdata = v.bwd;
        iss_valid = v.iv; iss_rd = v.ird; flush = v.fl;
        rs1 = v.r1; rs2 = v.r2;
        #1;
        chk($sformatf("v%0d a_ready", idx), {31'd0, a_ready}, {31'd0, v.e_ar});
        chk($sformatf("v%0d b_ready", idx), {31'd0, b_ready}, {31'd0, v.e_br});
        chk($sformatf("v%0d hazard", idx), {31'd0, hazard}, {31'd0, v.e_hz});
        step();
        chk($sformatf("v%0d rf_we", idx), {31'd0, rf_we}, {31'd0, v.e_we});
        chk($sformatf("v%0d rf_rd", idx), {27'd0, rf_rd}, {27'd0, v.e_rd});
        chk($sformatf("v%0d rf_wdata", idx), rf_wdata, v.e_wd);
        chk($sformatf("v%0d busy", idx), busy, v.e_busy);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("reset rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset rf_rd", {27'd0, rf_rd}, 32'd0);
        chk("reset rf_wdata", rf_wdata, 32'd0);
        chk("reset busy", busy, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        logic [4:0] a_rds [3];
        logic [4:0] b_rds [3];
        int ai, bi;
        logic exp_a;

        for (int i = 0; i < 32; i++) tb_rf[i] = 32'd0;
        idle_inputs();

        //         av    ard     awd            bv    brd     bwd            iv    ird    fl    r1     r2     ar    br    hz    we    rd     wd             busy
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h12345678, 32'h80};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h12345678, 32'h0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h12345678, 32'h0};
        vecs[6]  = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99,       32'h200};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h99,       32'h200};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 32'h99,       32'h200};
        vecs[9]  = '{1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h99,       32'h200};
        vecs[10] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h44,       32'h200};
        vecs[11] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd6, 32'h66,       1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33,       32'h200};
        vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h33,       32'h0};

        reset_n = 1'b0;
        #22;
        do_reset();

        for (int i = 0; i < 13; i++) apply_vec(vecs[i], i);

        // Scoreboard fill then flush with a same-cycle issue
        idle_inputs();
        for (int r = 8; r < 12; r++) begin
            iss_valid = 1'b1;
            iss_rd = 5'(r);
            step();
        end
        idle_inputs();
        #1;
        chk("busy fill", busy, 32'h0000_0F00);
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd3;
        step();
        idle_inputs();
        rs1 = 5'd3;
        #1;
        chk("flush+issue busy", busy, 32'h0000_0008);
        chk("flush+issue hazard", {31'd0, hazard}, 32'd1);

        // Hazard release timing and register file visibility for x7
        idle_inputs();
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        idle_inputs();
        rs1 = 5'd7;
        b_valid = 1'b1; b_rd = 5'd7; b_wdata = 32'hCAFEF00D;
        #1;
        chk("x7 hazard before wb", {31'd0, hazard}, 32'd1);
        chk("x7 b_ready", {31'd0, b_ready}, 32'd1);
        step();
        b_valid = 1'b0;
        #1;
        chk("x7 hazard cycle N+1", {31'd0, hazard}, 32'd1);
        step();
        chk("x7 hazard cycle N+2", {31'd0, hazard}, 32'd0);
        chk("x7 rf read N+2", tb_rf[7], 32'hCAFEF00D);

        // Fresh reset, then four cycles of contention: grants A,B,A,B
        idle_inputs();
        do_reset();
        a_rds[0] = 5'd1;  a_rds[1] = 5'd3;  a_rds[2] = 5'd11;
        b_rds[0] = 5'd2;  b_rds[1] = 5'd4;  b_rds[2] = 5'd12;
        ai = 0;
        bi = 0;
        for (int c = 0; c < 4; c++) begin
            a_valid = 1'b1; a_rd = a_rds[ai]; a_wdata = {27'd0, a_rds[ai]} + 32'h100;
            b_valid = 1'b1; b_rd = b_rds[bi]; b_wdata = {27'd0, b_rds[bi]} + 32'h200;
            exp_a = (c % 2 == 0);
            #1;
            chk($sformatf("cont%0d one-hot", c), {31'd0, a_ready & b_ready}, 32'd0);
            chk($sformatf("cont%0d a_ready", c), {31'd0, a_ready}, {31'd0, exp_a});
            chk($sformatf("cont%0d b_ready", c), {31'd0, b_ready}, {31'd0, ~exp_a});
            if (exp_a) begin
                exp_q.push_back(a_rds[ai]);
                ai++;
            end else begin
                exp_q.push_back(b_rds[bi]);
                bi++;
            end
            step();
            chk($sformatf("cont%0d rf_we", c), {31'd0, rf_we}, 32'd1);
            chk($sformatf("cont%0d rf_rd", c), {27'd0, rf_rd}, {27'd0, exp_q.pop_front()});
        end

        // Reset asserted while a write is in flight
        idle_inputs();
        iss_valid = 1'b1; iss_rd = 5'd12;
        a_valid = 1'b1; a_rd = 5'd13; a_wdata = 32'hABCD;
        #1;
        chk("midrst a_ready", {31'd0, a_ready}, 32'd1);
        step();
        idle_inputs();
        chk("midrst rf_we before", {31'd0, rf_we}, 32'd1);
        chk("midrst busy before", busy, 32'h0000_1000);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst rf_we", {31'd0, rf_we}, 32'd0);
        chk("midrst busy", busy, 32'd0);
        chk("midrst a_ready", {31'd0, a_ready}, 32'd0);
        #3;
        reset_n = 1'b1;
        step();
        chk("post-reset rf_we", {31'd0, rf_we}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 register file. It shares the register file's single synchronous write port between two writeback sources: A (ALU results) and B (load data). It also tracks destination registers with writes still outstanding and raises a read-after-write hazard for the decode stage. It sits between the execute/load units and the register file write port (we/rd/wdata).

## Interface
- XLEN, 32, data width
- NREG, 32, number of architectural registers; register 0 is hard-wired zero
- AW, 5, register address width (log2 NREG)

- clk  in  1  clock; all state changes on posedge
- reset_n  in  1  asynchronous, active-low reset
- a_valid  in  1  source A has a writeback pending
- a_ready  out  1  source A is granted this cycle
- a_rd  in  AW  source A destination
- a_wdata  in  XLEN  source A data
- b_valid, b_ready, b_rd, b_wdata  same as the A group, for source B
- iss_valid  in  1  an instruction with a destination issued this cycle
- iss_rd  in  AW  destination of the issued instruction
- flush  in  1  clear the scoreboard
- rs1, rs2  in  AW  decode-stage source operands
- hazard  out  1  rs1 or rs2 has an outstanding write
- busy  out  NREG  scoreboard vector
- rf_we  out  1  register file write enable
- rf_rd  out  AW  register file write address
- rf_wdata  out  XLEN  register file write data

## Operation
- Handshake: a transfer occurs when valid and ready are both 1 at a posedge.
  - ready depends on valid; valid must not depend on ready.
  - A source holds rd and wdata stable while valid=1 and ready=0.
- Arbitration is 2-way round-robin.
  - Only one source valid: that source is granted.
  - Both valid: the source not granted last is granted.
  - The `last` pointer updates only on a completed transfer.
  - After reset, `last` = B, so A wins the first contention.
- Grant is combinational. At most one ready is high per cycle. ready=0 when the matching valid=0.
- Accepted write: registered into rf_we/rf_rd/rf_wdata on the transfer edge.
  - rf_we=1 for exactly one cycle.
  - If rd=0, the transfer still completes, but rf_we stays 0.
- No transfer this cycle: rf_we=0 next cycle; rf_rd and rf_wdata hold their last values.
- Scoreboard, busy[NREG-1:0]:
  - Set: iss_valid=1 and iss_rd≠0 sets busy[iss_rd].
  - Clear: a cycle with rf_we=1 clears busy[rf_rd] at that edge, the same edge the register file commits the write.
  - Set and clear of the same register at one edge: set wins (new owner).
  - flush=1 clears all bits, then the same-cycle iss_valid set is applied.
  - busy[0] is always 0.
- Hazard, combinational: (rs1≠0 & busy[rs1]) | (rs2≠0 & busy[rs2]).
- Writebacks for registers not marked busy are legal: they are written and busy is unchanged.

## Timing
- Reset (reset_n=0, asynchronous):
  - rf_we=0, rf_rd=0, rf_wdata=0, busy=0, last=B.
  - hazard=0 and a_ready=b_ready=0 unless the corresponding valid is asserted.
- Reset asserted mid-transfer: the pending output write is dropped (rf_we forced 0) and the scoreboard is lost. Sources re-present after release.
- Latency:
  - Handshake edge N: rf_we=1 during cycle N+1, and the register file updates at edge N+1.
  - busy[rd] reads 0 from cycle N+2. The register file read returns the new value in the same cycle N+2, so a stalled reader never sees stale data.
- Throughput: one write per cycle; sustained contention alternates A,B,A,B.
- Starvation: a continuously valid source waits at most 1 cycle.

## Structure
- Shared package holds XLEN, NREG and AW, plus the source-select enum {SRC_A, SRC_B} used by `last`.
- Sub-module rr_arb2: 2-requester round-robin arbiter.
  - Inputs: req[1:0], advance (transfer done).
  - Output: one-hot gnt[1:0].
  - Contains the `last` flop with asynchronous active-low reset.
- Top level holds the output write register, the scoreboard vector and the hazard compare.

## Test plan
- Reset then a single write: pulse reset_n low; busy=0 and rf_we=0. Then a_valid, a_rd=5, a_wdata=0xDEADBEEF → a_ready=1; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF.
- Contention: a_valid and b_valid held 1 for 4 cycles with distinct rd → grants A,B,A,B; rf_rd sequence matches; no cycle with both ready.
- Scoreboard: iss_valid, iss_rd=7 → busy[7]=1. rs1=7 → hazard=1. B writes rd=7 → hazard drops two cycles after the handshake, and the read of x7 returns the new data.
- Simultaneous set/clear: rf_we=1 with rf_rd=9 in the same cycle as iss_valid with iss_rd=9 → busy[9] remains 1.
- x0 handling: iss_rd=0 → busy unchanged. Writeback to rd=0 → handshake completes, rf_we stays 0, and hazard with rs1=rs2=0 is 0.
- Flush and reset mid-operation: busy=0x0000_0F00, then flush with iss_rd=3 → busy=0x0000_0008. Assert reset_n low during a handshake → rf_we=0 immediately (asynchronous) and busy=0.
